// File: rtl/sram1rw_arbiter.sv
// Round-robin two-port arbiter and sequencer for a 1RW SRAM macro with held read responses.
// Define SRAM1RW_ARB_INIT_EN to clear the array with INIT_VALUE after every reset.
module sram1rw_arbiter #(
  parameter int unsigned       DEPTH      = 64,
  parameter int unsigned       ADDR_W     = 6,
  parameter int unsigned       DATA_W     = 21,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [2*DATA_W-1:0]   resp_data,
  output logic                  init_done,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_i,
  input  logic [DATA_W-1:0]     sram_o,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic                  sram_oeb
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

`ifdef SRAM1RW_ARB_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
`else
  localparam state_e RST_STATE = ST_RUN;
`endif

  state_e                   state_q, state_d;
  logic                     init_done_q, init_done_d;
  logic                     rr_q, rr_d;
  logic [1:0]               vld_q, vld_d;
  logic [1:0]               fresh_q, fresh_d;
  logic [1:0][DATA_W-1:0]   hold_q, hold_d;
  logic [ADDR_W-1:0]        a_q, a_d;
  logic [DATA_W-1:0]        i_q, i_d;

  logic [1:0]               elig, gnt;
  logic                     gp;
  logic                     init_acc;

  // Sequencer: init sweep (when built in) and the init_done flag
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    init_acc    = 1'b0;
`ifdef SRAM1RW_ARB_INIT_EN
    cnt_d = cnt_q;
    if (state_q == ST_INIT && !rst) begin
      init_acc = 1'b1;
      cnt_d    = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
`else
    init_done_d = 1'b1;
`endif
  end

  // Eligibility and round-robin grant; a read waits only on its own unconsumed response
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      elig[p] = req_valid[p] && init_done_q && (req_write[p] || !vld_q[p] || resp_ready[p]);
    end
    gnt = elig;
    if (elig == 2'b11) begin
      gnt = rr_q ? 2'b10 : 2'b01;
    end
    gp   = gnt[1];
    rr_d = (gnt != 2'b00) ? !gp : rr_q;
  end

  // Macro drive; address and write data hold their last driven value when idle
  always_comb begin
    sram_csb = 1'b1;
    sram_web = 1'b1;
    sram_oeb = 1'b1;
    sram_a   = a_q;
    sram_i   = i_q;
    if (init_acc) begin
`ifdef SRAM1RW_ARB_INIT_EN
      sram_a = cnt_q;
`endif
      sram_csb = 1'b0;
      sram_web = 1'b0;
      sram_i   = INIT_VALUE;
    end else if (gnt != 2'b00) begin
      sram_csb = 1'b0;
      sram_a   = gp ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      if (req_write[gp]) begin
        sram_web = 1'b0;
        sram_i   = gp ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end else begin
        sram_oeb = 1'b0;
      end
    end
    a_d = sram_a;
    i_d = sram_i;
  end

  // Response channels: fresh data comes straight from the macro, then from the hold register
  always_comb begin
    vld_d     = vld_q;
    fresh_d   = 2'b00;
    hold_d    = hold_q;
    resp_data = '0;
    for (int p = 0; p < 2; p++) begin
      if (fresh_q[p] && !resp_ready[p]) hold_d[p] = sram_o;
      if (resp_ready[p]) vld_d[p] = 1'b0;
      if (gnt[p] && !req_write[p]) begin
        vld_d[p]   = 1'b1;
        fresh_d[p] = 1'b1;
      end
      resp_data[p*DATA_W +: DATA_W] = fresh_q[p] ? sram_o : hold_q[p];
    end
  end

  assign req_ready  = gnt;
  assign resp_valid = vld_q;
  assign init_done  = init_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      init_done_q <= 1'b0;
      rr_q        <= 1'b0;
      vld_q       <= 2'b00;
      fresh_q     <= 2'b00;
      hold_q      <= '0;
      a_q         <= '0;
      i_q         <= '0;
`ifdef SRAM1RW_ARB_INIT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      vld_q       <= vld_d;
      fresh_q     <= fresh_d;
      hold_q      <= hold_d;
      a_q         <= a_d;
      i_q         <= i_d;
`ifdef SRAM1RW_ARB_INIT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sram1rw_arbiter.sv
// Bench for sram1rw_arbiter: 64x21 macro model plus a transaction-level reference of the arbiter.
// Honours SRAM1RW_ARB_INIT_EN the same way as the design.
module tb_sram1rw_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, req_write, resp_valid, resp_ready;
  logic [11:0] req_addr;
  logic [41:0] req_wdata, resp_data;
  logic        init_done;
  logic [5:0]  sram_a;
  logic [20:0] sram_i, sram_o;
  logic        sram_csb, sram_web, sram_oeb;

  sram1rw_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_a(sram_a), .sram_i(sram_i), .sram_o(sram_o),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_oeb(sram_oeb)
  );

  always #5 clk = ~clk;

  // Macro model: registered read data, write has priority over output enable
  logic [20:0] mem [64];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int k = 0; k < 64; k++) begin
`ifdef SRAM1RW_ARB_INIT_EN
        mem[k] <= 21'($urandom);
`else
        mem[k] <= 21'd0;
`endif
      end
    end else if (!sram_csb) begin
      if (!sram_web) mem[sram_a] <= sram_i;
      else if (!sram_oeb) sram_o <= mem[sram_a];
    end
  end

  // Reference state: array contents, pending response per port, rr pointer
  logic [20:0] m_mem [64];
  logic [1:0]  m_valid;
  logic [20:0] m_data [2];
  int          m_rr;
  logic        m_done;
  int          last_gnt;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 2'b00;
    m_rr    = 0;
    m_done  = 1'b0;
    for (int k = 0; k < 64; k++) m_mem[k] = 21'd0;
  endtask

  // One clock cycle of stimulus, predicted grant, and response checks
  task automatic cycle(input logic [1:0] v, input logic [1:0] w, input logic [1:0] rdy,
                       input logic [5:0] a0, input logic [5:0] a1,
                       input logic [20:0] d0, input logic [20:0] d1);
    logic [1:0]  e, g;
    int          gp;
    logic [5:0]  ga;
    logic [20:0] gd;
    @(negedge clk);
    req_valid  = v;
    req_write  = w;
    resp_ready = rdy;
    req_addr   = {a1, a0};
    req_wdata  = {d1, d0};
    for (int p = 0; p < 2; p++) e[p] = v[p] && m_done && (w[p] || !m_valid[p] || rdy[p]);
    gp = 0;
    if (e == 2'b11) gp = m_rr;
    else if (e[1]) gp = 1;
    g = 2'b00;
    if (e != 2'b00) g[gp] = 1'b1;
    ga = (gp == 1) ? a1 : a0;
    gd = (gp == 1) ? d1 : d0;
    #1;
    chk("req_ready", req_ready, g);
    if (e != 2'b00) begin
      chk("sram_ctl", {sram_csb, sram_web, sram_oeb, sram_a}, {1'b0, !w[gp], w[gp], ga});
      if (w[gp]) chk("sram_i", sram_i, gd);
    end else begin
      chk("sram_idle", {sram_csb, sram_web, sram_oeb}, 3'b111);
    end
    for (int p = 0; p < 2; p++) if (m_valid[p] && rdy[p]) m_valid[p] = 1'b0;
    last_gnt = -1;
    if (e != 2'b00) begin
      last_gnt = gp;
      if (w[gp]) m_mem[ga] = gd;
      else begin
        m_valid[gp] = 1'b1;
        m_data[gp]  = m_mem[ga];
      end
      m_rr = 1 - gp;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("resp_valid%0d", p), resp_valid[p], m_valid[p]);
      if (m_valid[p]) chk($sformatf("resp_data%0d", p), resp_data[p*21 +: 21], m_data[p]);
    end
  endtask

  // Called with reset just released at a falling edge; waits for init_done with a bound
  task automatic wait_init();
    int n;
    n = 0;
    req_valid  = 2'b11;
    req_write  = 2'b00;
    resp_ready = 2'b00;
    while (n < 200) begin
      #1;
      chk("init_ready_low", req_ready, 2'b00);
`ifdef SRAM1RW_ARB_INIT_EN
      chk("init_access", {sram_csb, sram_web, sram_oeb, sram_a, sram_i},
          {3'b001, 6'(n), 21'd0});
`else
      chk("init_no_access", sram_csb, 1'b1);
`endif
      @(posedge clk);
      #1;
      n++;
      if (init_done === 1'b1) break;
      @(negedge clk);
    end
    req_valid = 2'b00;
`ifdef SRAM1RW_ARB_INIT_EN
    chk("init_cycles", 64'(n), 64'd64);
`else
    chk("init_cycles", 64'(n), 64'd1);
`endif
    m_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    preload = 1'b1;
    req_valid = 2'b00; req_write = 2'b00; resp_ready = 2'b00;
    req_addr = '0; req_wdata = '0;
    model_reset();
    #3;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_ctl", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("rst_a_i", {sram_a, sram_i}, 27'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    rst = 1'b0;
    wait_init();

    // Contention: both ports read every cycle, grants must alternate from port 0
    for (int i = 0; i < 8; i++) begin
      cycle(2'b11, 2'b00, 2'b11, 6'(i), 6'(8 + i), 21'd0, 21'd0);
      chk("rr_order", 64'(last_gnt), 64'(i % 2));
    end
    cycle(2'b01, 2'b00, 2'b11, 6'd37, 6'd0, 21'd0, 21'd0);
    chk("read37", resp_data[20:0], 21'd0);

    // Single port write then read-after-write
    cycle(2'b01, 2'b01, 2'b11, 6'd5, 6'd0, 21'h1ABCDE, 21'd0);
    cycle(2'b01, 2'b00, 2'b11, 6'd5, 6'd0, 21'd0, 21'd0);
    chk("raw_data", resp_data[20:0], 21'h1ABCDE);

    // Held response survives other-port traffic; port 0 read blocked until consumed
    cycle(2'b01, 2'b01, 2'b11, 6'd3, 6'd0, 21'h000111, 21'd0);
    cycle(2'b01, 2'b00, 2'b10, 6'd3, 6'd0, 21'd0, 21'd0);
    cycle(2'b11, 2'b10, 2'b10, 6'd4, 6'd3, 21'd0, 21'h1FFFFF);
    cycle(2'b11, 2'b00, 2'b10, 6'd4, 6'd9, 21'd0, 21'd0);
    for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00, 2'b10, 6'd4, 6'd0, 21'd0, 21'd0);
    chk("hold_data", resp_data[20:0], 21'h000111);
    chk("hold_blocked", 64'(last_gnt), -64'sd1);
    cycle(2'b01, 2'b00, 2'b11, 6'd4, 6'd0, 21'd0, 21'd0);
    chk("hold_release", 64'(last_gnt), 64'd0);
    cycle(2'b00, 2'b00, 2'b11, 6'd0, 6'd0, 21'd0, 21'd0);

    // Port 1 streams reads with consume-and-reissue each cycle
    for (int i = 0; i < 8; i++) begin
      cycle(2'b10, 2'b00, 2'b10, 6'd0, 6'(i), 21'd0, 21'd0);
      chk("stream_accept", 64'(last_gnt), 64'd1);
    end
    cycle(2'b00, 2'b00, 2'b11, 6'd0, 6'd0, 21'd0, 21'd0);

    // Randomized traffic over a narrow address window
    for (int i = 0; i < 400; i++) begin
      cycle(2'($urandom), 2'($urandom), 2'($urandom),
            6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
            21'($urandom), 21'($urandom));
    end
    cycle(2'b00, 2'b00, 2'b11, 6'd0, 6'd0, 21'd0, 21'd0);

    // Reset mid-stream with a pending port 0 response
    cycle(2'b01, 2'b00, 2'b00, 6'd2, 6'd0, 21'd0, 21'd0);
    chk("pre_rst_pending", resp_valid[0], 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b10;
    #1;
    chk("midrst_resp_valid", resp_valid, 2'b00);
    chk("midrst_ctl", {sram_csb, sram_web, sram_oeb}, 3'b111);
    chk("midrst_req_ready", req_ready, 2'b00);
    chk("midrst_init_done", init_done, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst_ctl_hold", {sram_csb, sram_web, sram_oeb}, 3'b111);
    rst = 1'b0;
    model_reset();
`ifndef SRAM1RW_ARB_INIT_EN
    for (int k = 0; k < 64; k++) m_mem[k] = mem[k];
`endif
    wait_init();

    cycle(2'b11, 2'b00, 2'b11, 6'd2, 6'd5, 21'd0, 21'd0);
    chk("post_rst_rr", 64'(last_gnt), 64'd0);
    cycle(2'b10, 2'b10, 2'b11, 6'd0, 6'd7, 21'd0, 21'h0ACE5);
    cycle(2'b01, 2'b00, 2'b11, 6'd7, 6'd0, 21'd0, 21'd0);
    cycle(2'b00, 2'b00, 2'b11, 6'd0, 6'd0, 21'd0, 21'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
